// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-RAM write port and loader status, bundled for the loader.
// No latency of its own; it only carries signals.
// The host drives byte_valid and the loader drives byte_ready; all loader outputs are registered.
interface imem_loader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 7
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0]      wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    // Host / system side: issues start and bytes, observes writes and status.
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );

    // Loader side.
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Loads the instruction RAM from a host byte stream: count byte, 4*C little-endian data bytes, XOR checksum.
// Latency: a word is written in the cycle after its 4th byte is accepted; done/err rise the cycle after the last byte.
// Backpressure: byte_ready is registered and high only while loading, so it accepts one byte per cycle with no stall.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t            state;
    // One extra bit so that a full-memory load (C == DEPTH) can be counted.
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_nxt;
    logic [ADDR_W:0]   count;
    logic [1:0]        lane;
    // Bytes 0..2 of the word being assembled; byte 0 ends up in the low lane.
    logic [23:0]       low_bytes;
    logic [7:0]        csum;
    logic              accept;
    logic [31:0]       byte_ext;
    logic              count_bad;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign word_nxt  = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign byte_ext  = {24'd0, bus.byte_data};
    assign count_bad = (byte_ext == 32'd0) || (byte_ext > 32'(DEPTH));

    // Load sequencer: state, word assembly, checksum and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            word_cnt       <= '0;
            count          <= '0;
            lane           <= '0;
            low_bytes      <= '0;
            csum           <= '0;
            bus.byte_ready <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.cpu_hold   <= 1'b1;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            bus.wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state          <= COUNT;
                        bus.byte_ready <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.err        <= 1'b0;
                        bus.cpu_hold   <= 1'b1;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (count_bad) begin
                            state          <= ERROR;
                            bus.err        <= 1'b1;
                            bus.busy       <= 1'b0;
                            bus.byte_ready <= 1'b0;
                        end else begin
                            state    <= DATA;
                            count    <= byte_ext[ADDR_W:0];
                            word_cnt <= '0;
                            lane     <= '0;
                            csum     <= '0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum      <= csum ^ bus.byte_data;
                        lane      <= lane + 2'd1;
                        low_bytes <= {bus.byte_data, low_bytes[23:8]};
                        if (lane == 2'd3) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= word_cnt[ADDR_W-1:0];
                            bus.wr_data <= N'({bus.byte_data, low_bytes});
                            word_cnt    <= word_nxt;
                            if (word_nxt == count) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        bus.byte_ready <= 1'b0;
                        bus.busy       <= 1'b0;
                        if (bus.byte_data == csum) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            bus.err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded writes plus status checks per scenario.
module tb_imem_loader;
    localparam int N      = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    imem_loader #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_t;

    int checks   = 0;
    int failures = 0;

    // Write monitor: records every observed write with its cycle stamp.
    int                cyc     = 0;
    int                obs_cnt = 0;
    logic [ADDR_W-1:0] obs_addr [0:1023];
    logic [N-1:0]      obs_data [0:1023];
    int                obs_cyc  [0:1023];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en === 1'b1) begin
            obs_addr[obs_cnt] <= bus.wr_addr;
            obs_data[obs_cnt] <= bus.wr_data;
            obs_cyc[obs_cnt]  <= cyc;
            obs_cnt           <= obs_cnt + 1;
        end
    end

    wr_t        exp_q [$];
    logic [7:0] stream [$];
    int         rd_ptr = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Build a stream for the given words and queue the expected writes.
    task automatic build(input logic [N-1:0] words [$], input logic [7:0] corrupt);
        logic [7:0] x;
        logic [7:0] b;
        wr_t        e;
        x = 8'h00;
        stream.delete();
        stream.push_back(8'(words.size()));
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                x = x ^ b;
                stream.push_back(b);
            end
            e.addr = i[ADDR_W-1:0];
            e.data = words[i];
            exp_q.push_back(e);
        end
        stream.push_back(x ^ corrupt);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout byte_ready=%b required 1", bus.byte_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input int gap_max);
        foreach (stream[i]) send_byte(stream[i], $urandom_range(gap_max, 0));
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.byte_ready, bus.busy, bus.done, bus.err, bus.cpu_hold, bus.wr_en} !== 6'b000010) begin
            failures++;
            $display("FAIL reset_status got rdy,busy,done,err,hold,wr_en=%b required 000010",
                     {bus.byte_ready, bus.busy, bus.done, bus.err, bus.cpu_hold, bus.wr_en});
        end
        checks++;
        if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            failures++;
            $display("FAIL reset_wr_bus got addr=%0d data=%h required 0/0", bus.wr_addr, bus.wr_data);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.byte_ready, bus.busy, bus.cpu_hold} !== 3'b001) begin
            failures++;
            $display("FAIL idle_after_reset got rdy,busy,hold=%b required 001",
                     {bus.byte_ready, bus.busy, bus.cpu_hold});
        end
    endtask

    task automatic test_single();
        logic [N-1:0] w [$];
        wr_t e;
        w.push_back(32'hf8000001);
        build(w, 8'h00);
        checks++;
        if (stream[5] !== 8'hf9) begin
            failures++;
            $display("FAIL single_stream_csum got %h required f9", stream[5]);
        end
        pulse_start();
        checks++;
        if ({bus.busy, bus.byte_ready, bus.cpu_hold, bus.done} !== 4'b1110) begin
            failures++;
            $display("FAIL start_to_count got busy,rdy,hold,done=%b required 1110",
                     {bus.busy, bus.byte_ready, bus.cpu_hold, bus.done});
        end
        send_stream(0);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.byte_ready, bus.busy} !== 5'b10000) begin
            failures++;
            $display("FAIL single_result got done,err,hold,rdy,busy=%b required 10000",
                     {bus.done, bus.err, bus.cpu_hold, bus.byte_ready, bus.busy});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt) begin
                failures++;
                $display("FAIL single_write got none required addr=%0d data=%h", e.addr, e.data);
            end else begin
                if (obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                    failures++;
                    $display("FAIL single_write got addr=%0d data=%h required addr=%0d data=%h",
                             obs_addr[rd_ptr], obs_data[rd_ptr], e.addr, e.data);
                end
                rd_ptr++;
            end
        end
        checks++;
        if (obs_cnt != rd_ptr) begin
            failures++;
            $display("FAIL single_write_count got %0d required %0d", obs_cnt, rd_ptr);
        end
    endtask

    task automatic test_full();
        logic [N-1:0] w [$];
        wr_t e;
        int  base;
        int  bad_gap;
        for (int i = 0; i < DEPTH; i++) w.push_back(i * 32'h01010101);
        build(w, 8'h00);
        base = rd_ptr;
        pulse_start();
        send_stream(0);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL full_result got done,err,hold=%b required 100", {bus.done, bus.err, bus.cpu_hold});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt) begin
                failures++;
                $display("FAIL full_write got none required addr=%0d data=%h", e.addr, e.data);
            end else begin
                if (obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                    failures++;
                    $display("FAIL full_write got addr=%0d data=%h required addr=%0d data=%h",
                             obs_addr[rd_ptr], obs_data[rd_ptr], e.addr, e.data);
                end
                rd_ptr++;
            end
        end
        checks++;
        if (obs_cnt != rd_ptr) begin
            failures++;
            $display("FAIL full_write_count got %0d required %0d", obs_cnt, rd_ptr);
        end
        bad_gap = 0;
        for (int i = base + 1; i < rd_ptr; i++) if (obs_cyc[i] - obs_cyc[i-1] != 4) bad_gap++;
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL full_write_spacing got %0d gaps not 4 cycles required 0", bad_gap);
        end
    endtask

    task automatic test_bad_checksum();
        logic [N-1:0] w [$];
        wr_t e;
        w.push_back(32'hf8000001);
        build(w, 8'hf9);
        pulse_start();
        send_stream(0);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.byte_ready} !== 4'b0110) begin
            failures++;
            $display("FAIL badsum_result got done,err,hold,rdy=%b required 0110",
                     {bus.done, bus.err, bus.cpu_hold, bus.byte_ready});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt) begin
                failures++;
                $display("FAIL badsum_write got none required addr=%0d data=%h", e.addr, e.data);
            end else begin
                if (obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                    failures++;
                    $display("FAIL badsum_write got addr=%0d data=%h required addr=%0d data=%h",
                             obs_addr[rd_ptr], obs_data[rd_ptr], e.addr, e.data);
                end
                rd_ptr++;
            end
        end
        w.delete();
        w.push_back(32'h12345678);
        build(w, 8'h00);
        pulse_start();
        send_stream(0);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL recover_result got done,err,hold=%b required 100", {bus.done, bus.err, bus.cpu_hold});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt || obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                failures++;
                $display("FAIL recover_write got count=%0d required addr=%0d data=%h", obs_cnt - rd_ptr, e.addr, e.data);
            end
            if (rd_ptr < obs_cnt) rd_ptr++;
        end
    endtask

    task automatic test_illegal_count();
        logic [7:0] counts [2];
        counts[0] = 8'h00;
        counts[1] = 8'hc8;
        foreach (counts[i]) begin
            pulse_start();
            send_byte(counts[i], 0);
            bus.byte_valid = 1'b0;
            checks++;
            if ({bus.err, bus.done, bus.byte_ready, bus.cpu_hold} !== 4'b1001) begin
                failures++;
                $display("FAIL illegal_count_%h got err,done,rdy,hold=%b required 1001",
                         counts[i], {bus.err, bus.done, bus.byte_ready, bus.cpu_hold});
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'h01;
            repeat (6) @(negedge clk);
            bus.byte_valid = 1'b0;
            checks++;
            if (obs_cnt != rd_ptr || bus.err !== 1'b1) begin
                failures++;
                $display("FAIL illegal_count_%h_quiet got writes=%0d err=%b required 0 and 1",
                         counts[i], obs_cnt - rd_ptr, bus.err);
            end
        end
    endtask

    task automatic test_handshake();
        logic [N-1:0] w [$];
        wr_t e;
        w.push_back(32'hdeadbeef);
        w.push_back(32'h0badf00d);
        w.push_back($urandom());
        build(w, 8'h00);
        pulse_start();
        foreach (stream[i]) begin
            if (i == 6) begin
                bus.byte_valid = 1'b0;
                pulse_start();
            end
            send_byte(stream[i], $urandom_range(3, 0));
        end
        bus.byte_valid = 1'b0;
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL stress_result got done,err,hold=%b required 100", {bus.done, bus.err, bus.cpu_hold});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt) begin
                failures++;
                $display("FAIL stress_write got none required addr=%0d data=%h", e.addr, e.data);
            end else begin
                if (obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                    failures++;
                    $display("FAIL stress_write got addr=%0d data=%h required addr=%0d data=%h",
                             obs_addr[rd_ptr], obs_data[rd_ptr], e.addr, e.data);
                end
                rd_ptr++;
            end
        end
        checks++;
        if (obs_cnt != rd_ptr) begin
            failures++;
            $display("FAIL stress_write_count got %0d required %0d", obs_cnt, rd_ptr);
        end
    endtask

    task automatic test_reset_midload();
        logic [N-1:0] w [$];
        wr_t e;
        w.push_back(32'h11111111);
        w.push_back(32'h22222222);
        w.push_back(32'h33333333);
        build(w, 8'h00);
        void'(exp_q.pop_back());
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(stream[i], 0);
        bus.byte_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.byte_ready, bus.busy, bus.done, bus.err, bus.cpu_hold, bus.wr_en} !== 6'b000010
            || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            failures++;
            $display("FAIL midload_reset got rdy,busy,done,err,hold,wr_en=%b addr=%0d data=%h required 000010 0 0",
                     {bus.byte_ready, bus.busy, bus.done, bus.err, bus.cpu_hold, bus.wr_en}, bus.wr_addr, bus.wr_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt) begin
                failures++;
                $display("FAIL midload_write got none required addr=%0d data=%h", e.addr, e.data);
            end else begin
                if (obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                    failures++;
                    $display("FAIL midload_write got addr=%0d data=%h required addr=%0d data=%h",
                             obs_addr[rd_ptr], obs_data[rd_ptr], e.addr, e.data);
                end
                rd_ptr++;
            end
        end
        checks++;
        if (obs_cnt != rd_ptr) begin
            failures++;
            $display("FAIL midload_no_third_write got %0d extra required 0", obs_cnt - rd_ptr);
        end
        w.delete();
        w.push_back(32'hcafe0042);
        build(w, 8'h00);
        pulse_start();
        send_stream(0);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL after_reset_result got done,err,hold=%b required 100", {bus.done, bus.err, bus.cpu_hold});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_cnt || obs_addr[rd_ptr] !== e.addr || obs_data[rd_ptr] !== e.data) begin
                failures++;
                $display("FAIL after_reset_write got count=%0d required addr=%0d data=%h", obs_cnt - rd_ptr, e.addr, e.data);
            end
            if (rd_ptr < obs_cnt) rd_ptr++;
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_single();
        test_full();
        test_bad_checksum();
        test_illegal_count();
        test_handshake();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory: the write-side counterpart of the read-only instruction ROM. It takes a byte stream from a host link (UART/JTAG bridge) with a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word sequentially into the writable instruction RAM port, checks a trailing XOR checksum, and holds the processor core in reset until a load completes successfully.

## Interface
Parameters:
- N, 32, instruction word width; must be 32.
- ADDR_W, 7, instruction memory address width.
- DEPTH, 128, instruction memory words; maximum word count per load.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe; one cycle per word.
- wr_addr  out  ADDR_W  word address of the current write.
- wr_data  out  N  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  last load completed with a correct checksum.
- err  out  1  last load failed.
- cpu_hold  out  1  keeps the core in reset.

## Operation
- Byte transfer: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a registered output and does not depend combinationally on byte_valid.
- Stream format:
  - Byte 0 is the word count C, range 1..DEPTH.
  - Next come 4*C data bytes, least-significant byte first per word.
  - The final byte is the checksum: XOR of all 4*C data bytes. The count byte is excluded from the checksum.
- States:
  - IDLE: byte_ready=0, busy=0. start -> COUNT.
  - COUNT: byte_ready=1, busy=1.
    - On accept with C==0 or C>DEPTH -> ERROR.
    - Otherwise latch C, clear the word counter, byte lane and checksum -> DATA.
  - DATA: byte_ready=1. Each accepted byte goes into lane 0..3 and is XORed into the checksum.
    - On the 4th lane: register wr_data and wr_addr = word index, then pulse wr_en.
    - After word C-1 -> CHECK.
  - CHECK: byte_ready=1. On accept, byte == checksum -> DONE, else -> ERROR.
  - DONE: done=1, cpu_hold=0, busy=0. start -> COUNT, clearing done and raising cpu_hold.
  - ERROR: err=1, cpu_hold=1, busy=0. start -> COUNT, clearing err.
- Write addressing: addresses always start at 0 and increment by one per write. The internal word counter is ADDR_W+1 bits so that C==DEPTH is representable. wr_addr is the low ADDR_W bits of that counter.
- Errors do not undo writes already issued. Memory contents are never cleared by this block.
- start is ignored in COUNT, DATA and CHECK. byte_valid is ignored in IDLE, DONE and ERROR.

## Timing
- Reset values:
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - State IDLE.
- start sampled at edge k: the state is COUNT and byte_ready=1 from cycle k+1.
- Writes:
  - wr_en is high for exactly the one cycle following the edge that accepts the 4th byte of a word.
  - wr_addr and wr_data are valid in that same cycle and held until the next write.
- Back-to-back bytes are accepted at one per cycle with no stall. A write cycle overlaps acceptance of the next word's byte 0.
- Result timing:
  - done or err rises in the cycle after the checksum byte (or a bad count byte) is accepted.
  - cpu_hold falls in the same cycle done rises.
  - byte_ready is 0 from that cycle on.
- Reset deassertion mid-load is not required to resume. Reset assertion at any time forces the reset values immediately (asynchronous). Any partially assembled word is discarded, and no wr_en is issued for it.
- Gaps in byte_valid of any length are tolerated. Lane, counter and checksum hold their values.

## Test plan
- Single word:
  - Stimulus: start, then bytes 01, 01, 00, 00, f8, f9.
  - Response: one wr_en with wr_addr=0, wr_data=32'hf8000001. Then done=1, cpu_hold=0, err=0.
- Full memory:
  - Stimulus: C=128 (byte 8'h80), words = index*32'h01010101, correct checksum, byte_valid held high.
  - Response: 128 wr_en pulses, one every 4 cycles, with addresses 0..127 in order, then done=1.
- Bad checksum:
  - Stimulus: the single-word stream with checksum 00.
  - Response: write at address 0 still issued, then err=1, done=0, cpu_hold=1. A subsequent start and good stream gives done=1.
- Illegal counts:
  - Stimulus: count byte 00, and separately count byte 8'hc8.
  - Response: err=1 the next cycle, no wr_en, byte_ready=0.
- Handshake stress:
  - Stimulus: random byte_valid gaps on a 3-word load, plus start pulsed during DATA.
  - Response: identical writes and checksum result to the gap-free run. The extra start has no effect.
- Reset mid-load:
  - Stimulus: assert reset after 2 words plus 2 bytes of the 3rd.
  - Response: all outputs at reset values within the same cycle, and no third write. A fresh load then succeeds starting at wr_addr=0.
